// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: run-control states,
// NOP/HALT word encodings, PC step and address-width helper.
// No logic, no latency, no backpressure.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    // NOP is all zeros, HALT is all ones; expressed as a fill bit so any width works
    localparam logic NOP_FILL  = 1'b0;
    localparam logic HALT_FILL = 1'b1;

    localparam int unsigned PC_STEP = 4;

    // Word-address width for a memory of the given depth
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_imem.sv
// Instruction memory: one synchronous write port, one combinational read port.
// Read data is available in the same cycle; a write is visible from the next cycle.
// No backpressure: writes are always accepted.
module fetch_imem
    import fetch_pkg::*;
#(
    parameter int NB_BITS = 32,
    parameter int DEPTH   = 256
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [addr_w(DEPTH)-1:0]      waddr,
    input  logic [NB_BITS-1:0]            wdata,
    input  logic [addr_w(DEPTH)-1:0]      raddr,
    output logic [NB_BITS-1:0]            rdata
);

    logic [NB_BITS-1:0] mem [DEPTH];

    // Loader write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_stage_ctrl.sv
// MIPS fetch stage: PC, next-PC select, imem and IF/ID register with IDLE/RUN/HALTED run control.
// Latency: instruction at PC appears on IF/ID one cycle later. Optional counters via FETCH_PERF_CNT_EN.
// Backpressure: i_pc_we=0 holds PC (redirects dropped), i_if_id_we=0 holds IF/ID unless flushed.
module fetch_stage_ctrl
    import fetch_pkg::*;
#(
    parameter int                   NB_BITS    = 32,
    parameter int                   IMEM_DEPTH = 256,
    parameter logic [NB_BITS-1:0]   PC_RST     = '0
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_start,
    input  logic                              i_resume,
    input  logic [NB_BITS-1:0]                i_brq_addr,
    input  logic [NB_BITS-1:0]                i_jmp_addr,
    input  logic                              i_ctr_beq,
    input  logic                              i_ctr_jmp,
    input  logic                              i_ctr_flush,
    input  logic                              i_pc_we,
    input  logic                              i_if_id_we,
    input  logic                              i_mem_we,
    input  logic [addr_w(IMEM_DEPTH)-1:0]     i_mem_addr,
    input  logic [NB_BITS-1:0]                i_mem_data,
    output logic [NB_BITS-1:0]                o_if_id_pc,
    output logic [NB_BITS-1:0]                o_if_id_instr,
    output logic                              o_if_id_valid,
    output logic [NB_BITS-1:0]                o_pc,
    output logic [1:0]                        o_state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                       o_fetch_cnt,
    output logic [31:0]                       o_bubble_cnt
`endif
);

    localparam int unsigned        ADDR_W = addr_w(IMEM_DEPTH);
    localparam logic [NB_BITS-1:0] NOP_W  = {NB_BITS{NOP_FILL}};
    localparam logic [NB_BITS-1:0] HALT_W = {NB_BITS{HALT_FILL}};
    localparam logic [NB_BITS-1:0] STEP_W = NB_BITS'(PC_STEP);

    fetch_state_e       state, state_d;
    logic [NB_BITS-1:0] pc, pc_d, pc_plus4, fetch_word;
    logic [NB_BITS-1:0] if_id_pc, if_id_pc_d, if_id_instr, if_id_instr_d;
    logic               if_id_valid, if_id_valid_d;
    logic               halt_det;

    fetch_imem #(
        .NB_BITS (NB_BITS),
        .DEPTH   (IMEM_DEPTH)
    ) u_imem (
        .clk   (i_clk),
        .we    (i_mem_we),
        .waddr (i_mem_addr),
        .wdata (i_mem_data),
        .raddr (pc[ADDR_W+1:2]),
        .rdata (fetch_word)
    );

    assign pc_plus4 = pc + STEP_W;

    // A HALT word only stops the machine when it is on the correct path
    assign halt_det = (state == ST_RUN) && (fetch_word == HALT_W) &&
                      !i_ctr_jmp && !i_ctr_beq && !i_ctr_flush;

    // Run-control state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Run-control next state
    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE:   if (i_start)  state_d = ST_RUN;
            ST_RUN:    if (halt_det) state_d = ST_HALTED;
            ST_HALTED: if (i_resume) state_d = ST_RUN;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Next PC and next IF/ID contents for the current state
    always_comb begin
        pc_d          = pc;
        if_id_pc_d    = if_id_pc;
        if_id_instr_d = if_id_instr;
        if_id_valid_d = if_id_valid;
        unique case (state)
            ST_RUN: begin
                if (halt_det) begin
                    // PC parks on the HALT word so resume continues after it
                    if_id_pc_d    = pc_plus4;
                    if_id_instr_d = fetch_word;
                    if_id_valid_d = 1'b1;
                end else begin
                    if (i_pc_we) begin
                        if (i_ctr_jmp)      pc_d = i_jmp_addr;
                        else if (i_ctr_beq) pc_d = i_brq_addr;
                        else                pc_d = pc_plus4;
                    end
                    if (i_ctr_flush) begin
                        if_id_pc_d    = '0;
                        if_id_instr_d = NOP_W;
                        if_id_valid_d = 1'b0;
                    end else if (i_if_id_we) begin
                        if_id_pc_d    = pc_plus4;
                        if_id_instr_d = fetch_word;
                        if_id_valid_d = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                if (i_resume) pc_d = pc_plus4;
                if_id_pc_d    = '0;
                if_id_instr_d = NOP_W;
                if_id_valid_d = 1'b0;
            end
            default: begin
                if_id_pc_d    = '0;
                if_id_instr_d = NOP_W;
                if_id_valid_d = 1'b0;
            end
        endcase
    end

    // PC and IF/ID pipeline registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pc          <= PC_RST;
            if_id_pc    <= '0;
            if_id_instr <= NOP_W;
            if_id_valid <= 1'b0;
        end else begin
            pc          <= pc_d;
            if_id_pc    <= if_id_pc_d;
            if_id_instr <= if_id_instr_d;
            if_id_valid <= if_id_valid_d;
        end
    end

    assign o_pc          = pc;
    assign o_state       = state;
    assign o_if_id_pc    = if_id_pc;
    assign o_if_id_instr = if_id_instr;
    assign o_if_id_valid = if_id_valid;

`ifdef FETCH_PERF_CNT_EN
    logic        fetch_load, bubble_load;
    logic [31:0] fetch_cnt, bubble_cnt;

    assign fetch_load  = (state == ST_RUN) && (halt_det || (!i_ctr_flush && i_if_id_we));
    assign bubble_load = (state == ST_RUN) && i_ctr_flush;

    // Saturating event counters, restarted with each program run
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (i_start) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (fetch_load && (fetch_cnt != '1))   fetch_cnt  <= fetch_cnt + 32'd1;
            if (bubble_load && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + 32'd1;
        end
    end

    assign o_fetch_cnt  = fetch_cnt;
    assign o_bubble_cnt = bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
module tb_fetch_stage_ctrl;

    localparam int DEPTH = 256;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        i_clk = 1'b0;
    logic        i_rst, i_start, i_resume, i_ctr_beq, i_ctr_jmp, i_ctr_flush;
    logic        i_pc_we, i_if_id_we, i_mem_we;
    logic [31:0] i_brq_addr, i_jmp_addr, i_mem_data;
    logic [7:0]  i_mem_addr;
    logic [31:0] o_if_id_pc, o_if_id_instr, o_pc;
    logic        o_if_id_valid;
    logic [1:0]  o_state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] o_fetch_cnt, o_bubble_cnt;
`endif

    always #5 i_clk = ~i_clk;

    fetch_stage_ctrl #(.NB_BITS(32), .IMEM_DEPTH(DEPTH), .PC_RST(32'd0)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_resume(i_resume),
        .i_brq_addr(i_brq_addr), .i_jmp_addr(i_jmp_addr),
        .i_ctr_beq(i_ctr_beq), .i_ctr_jmp(i_ctr_jmp), .i_ctr_flush(i_ctr_flush),
        .i_pc_we(i_pc_we), .i_if_id_we(i_if_id_we),
        .i_mem_we(i_mem_we), .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data),
        .o_if_id_pc(o_if_id_pc), .o_if_id_instr(o_if_id_instr), .o_if_id_valid(o_if_id_valid),
        .o_pc(o_pc), .o_state(o_state)
`ifdef FETCH_PERF_CNT_EN
        , .o_fetch_cnt(o_fetch_cnt), .o_bubble_cnt(o_bubble_cnt)
`endif
    );

    // Reference model: architectural state only (0=IDLE, 1=RUN, 2=HALTED)
    logic [31:0] mem [DEPTH];
    int          m_state;
    logic [31:0] m_pc, m_ipc, m_ins, m_fcnt, m_bcnt;
    logic        m_vld;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pc = 32'd0; m_ipc = 32'd0; m_ins = 32'd0; m_vld = 1'b0;
        m_fcnt = 32'd0; m_bcnt = 32'd0;
    endtask

    // Apply one clock edge worth of architectural rules to the model
    task automatic model_step();
        logic [31:0] word, pc4;
        int nxt;
        word = mem[(m_pc / 4) % DEPTH];
        pc4  = m_pc + 32'd4;
        nxt  = m_state;
        if (m_state == 1) begin
            if (word == HALT && !i_ctr_jmp && !i_ctr_beq && !i_ctr_flush) begin
                m_ipc = pc4; m_ins = word; m_vld = 1'b1; nxt = 2;
                if (m_fcnt != HALT) m_fcnt++;
            end else begin
                if (i_pc_we) m_pc = i_ctr_jmp ? i_jmp_addr : (i_ctr_beq ? i_brq_addr : pc4);
                if (i_ctr_flush) begin
                    m_ipc = 0; m_ins = 0; m_vld = 1'b0;
                    if (m_bcnt != HALT) m_bcnt++;
                end else if (i_if_id_we) begin
                    m_ipc = pc4; m_ins = word; m_vld = 1'b1;
                    if (m_fcnt != HALT) m_fcnt++;
                end
            end
        end else begin
            m_ipc = 0; m_ins = 0; m_vld = 1'b0;
            if (m_state == 0 && i_start) nxt = 1;
            if (m_state == 2 && i_resume) begin
                m_pc = pc4; nxt = 1;
            end
        end
        if (i_start) begin
            m_fcnt = 0; m_bcnt = 0;
        end
        if (i_mem_we) mem[i_mem_addr] = i_mem_data;
        m_state = nxt;
    endtask

    task automatic check_all();
        chk("pc", o_pc, m_pc);
        chk("state", 32'(o_state), 32'(m_state));
        chk("if_id_pc", o_if_id_pc, m_ipc);
        chk("if_id_instr", o_if_id_instr, m_ins);
        chk("if_id_valid", 32'(o_if_id_valid), 32'(m_vld));
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt", o_fetch_cnt, m_fcnt);
        chk("bubble_cnt", o_bubble_cnt, m_bcnt);
`endif
    endtask

    // One clock: model advances with the current inputs, DUT sampled 1 time unit after the edge
    task automatic cycle();
        model_step();
        @(posedge i_clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        i_start = 0; i_resume = 0; i_ctr_beq = 0; i_ctr_jmp = 0; i_ctr_flush = 0;
        i_pc_we = 1; i_if_id_we = 1; i_mem_we = 0; i_mem_addr = 0; i_mem_data = 0;
        i_brq_addr = 0; i_jmp_addr = 0;
    endtask

    initial begin
        logic [31:0] w;
        i_rst = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        check_all();
        chk("rst_valid_lit", 32'(o_if_id_valid), 32'd0);
        i_rst = 1'b1;

        // Fill memory with non-HALT words while IDLE
        for (int a = 0; a < DEPTH; a++) begin
            w = $urandom();
            if (w == HALT) w = 32'h1234;
            case (a)
                0: w = 32'h11;
                1: w = 32'h22;
                2: w = 32'h33;
                3: w = HALT;
                4: w = 32'h55;
                default: ;
            endcase
            i_mem_we = 1; i_mem_addr = 8'(a); i_mem_data = w;
            cycle();
        end
        idle_inputs();
        chk("idle_pc_lit", o_pc, 32'd0);

        // Program run up to the HALT word
        i_start = 1; cycle(); i_start = 0;
        chk("start_state_lit", 32'(o_state), 32'd1);
        cycle(); chk("f0_pc_lit", o_if_id_pc, 32'd4);  chk("f0_ins_lit", o_if_id_instr, 32'h11);
        cycle(); chk("f1_pc_lit", o_if_id_pc, 32'd8);  chk("f1_ins_lit", o_if_id_instr, 32'h22);
        cycle(); chk("f2_pc_lit", o_if_id_pc, 32'd12); chk("f2_ins_lit", o_if_id_instr, 32'h33);
        cycle(); chk("f3_pc_lit", o_if_id_pc, 32'd16); chk("f3_ins_lit", o_if_id_instr, HALT);
        chk("f3_vld_lit", 32'(o_if_id_valid), 32'd1);
        chk("halt_state_lit", 32'(o_state), 32'd2); chk("halt_pc_lit", o_pc, 32'd12);
        i_start = 1; cycle(); i_start = 0;
        chk("halted_vld_lit", 32'(o_if_id_valid), 32'd0); chk("halted_pc_lit", o_pc, 32'd12);
        chk("halted_ign_start_lit", 32'(o_state), 32'd2);

        // Resume after HALT
        i_resume = 1; cycle(); i_resume = 0;
        chk("resume_state_lit", 32'(o_state), 32'd1); chk("resume_pc_lit", o_pc, 32'd16);
        cycle(); chk("r0_pc_lit", o_if_id_pc, 32'd20); chk("r0_ins_lit", o_if_id_instr, 32'h55);

        // Jump has priority over branch
        i_ctr_jmp = 1; i_ctr_beq = 1; i_jmp_addr = 100; i_brq_addr = 40; cycle();
        chk("jmp_prio_lit", o_pc, 32'd100);
        i_ctr_jmp = 0; cycle(); i_ctr_beq = 0;
        chk("beq_lit", o_pc, 32'd40);

        // Stall, flush during stall, then release
        i_pc_we = 0; i_if_id_we = 0;
        cycle(); chk("stall_pc_lit", o_pc, 32'd40); chk("stall_ifid_lit", o_if_id_pc, 32'd104);
        cycle(); chk("stall2_pc_lit", o_pc, 32'd40);
        i_ctr_flush = 1; cycle(); i_ctr_flush = 0;
        chk("flush_vld_lit", 32'(o_if_id_valid), 32'd0); chk("flush_ins_lit", o_if_id_instr, 32'd0);
        i_pc_we = 1; i_if_id_we = 1; cycle();
        chk("rel_pc_lit", o_pc, 32'd44); chk("rel_ifid_lit", o_if_id_pc, 32'd44);

        // HALT word on a branch-taken cycle is wrong-path
        i_ctr_jmp = 1; i_jmp_addr = 200; i_mem_we = 1; i_mem_addr = 50; i_mem_data = HALT; cycle();
        i_ctr_jmp = 0; i_mem_we = 0; i_ctr_beq = 1; i_brq_addr = 60; cycle(); i_ctr_beq = 0;
        chk("nohalt_pc_lit", o_pc, 32'd60); chk("nohalt_state_lit", 32'(o_state), 32'd1);

        // PC+4 wraps at the top of the address space
        i_ctr_jmp = 1; i_jmp_addr = 32'hFFFF_FFFC; cycle(); i_ctr_jmp = 0;
        cycle(); chk("wrap_pc_lit", o_pc, 32'd0); chk("wrap_ifid_lit", o_if_id_pc, 32'd0);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            i_start     = ($urandom_range(0, 99) < 2);
            i_resume    = ($urandom_range(0, 99) < 15);
            i_ctr_jmp   = ($urandom_range(0, 99) < 10);
            i_ctr_beq   = ($urandom_range(0, 99) < 12);
            i_ctr_flush = ($urandom_range(0, 99) < 10);
            i_pc_we     = ($urandom_range(0, 99) < 85);
            i_if_id_we  = ($urandom_range(0, 99) < 85);
            i_jmp_addr  = ($urandom_range(0, 19) == 0) ? $urandom() : 32'($urandom_range(0, 300)) << 2;
            i_brq_addr  = 32'($urandom_range(0, 300)) << 2;
            i_mem_we    = ($urandom_range(0, 99) < 6);
            i_mem_addr  = 8'($urandom_range(0, DEPTH - 1));
            i_mem_data  = ($urandom_range(0, 2) == 0) ? HALT : $urandom();
            cycle();
        end

        // Reach RUN, then reset asynchronously between edges
        idle_inputs();
        for (int n = 0; n < 20 && m_state != 1; n++) begin
            i_start = 1; i_resume = 1; cycle();
        end
        idle_inputs();
        i_ctr_jmp = 1; i_jmp_addr = 32'd16; cycle(); i_ctr_jmp = 0;
        cycle();
        #2;
        i_rst = 1'b0;
        #1;
        model_reset();
        chk("async_pc_lit", o_pc, 32'd0);
        chk("async_state_lit", 32'(o_state), 32'd0);
        chk("async_vld_lit", 32'(o_if_id_valid), 32'd0);
        chk("async_ins_lit", o_if_id_instr, 32'd0);
        check_all();
`ifdef FETCH_PERF_CNT_EN
        chk("async_fcnt_lit", o_fetch_cnt, 32'd0);
        chk("async_bcnt_lit", o_bubble_cnt, 32'd0);
`endif
        #2;
        i_rst = 1'b1;
        cycle(); cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage_ctrl.md
Name: fetch_stage_ctrl

Overview:
Parametrised MIPS instruction-fetch stage: PC register, next-PC selection (sequential/branch/jump), internal loadable instruction memory and IF/ID pipeline register. It adds three things the previous fetch block lacks:
- width/depth parametrisation;
- a start/halt/resume run-control FSM, so the debug unit can load a program and single-run it;
- a valid bit on the IF/ID output.

It sits between the debug/loader unit and the decode stage.

Parameters:
NB_BITS, 32, data/PC/instruction width
IMEM_DEPTH, 256, instruction memory depth in words (power of two)
PC_RST, 0, PC value loaded on reset

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous reset, active-low
i_start  in  1  pulse: leave IDLE and begin fetching
i_resume  in  1  pulse: leave HALTED and continue at PC+4
i_brq_addr  in  NB_BITS  branch target
i_jmp_addr  in  NB_BITS  jump target
i_ctr_beq  in  1  branch taken
i_ctr_jmp  in  1  jump taken
i_ctr_flush  in  1  squash the instruction entering IF/ID
i_pc_we  in  1  PC write enable (hazard unit stall when 0)
i_if_id_we  in  1  IF/ID write enable
i_mem_we  in  1  instruction memory write strobe
i_mem_addr  in  $clog2(IMEM_DEPTH)  word address for load
i_mem_data  in  NB_BITS  word to load
o_if_id_pc  out  NB_BITS  PC+4 of the instruction in IF/ID
o_if_id_instr  out  NB_BITS  instruction in IF/ID
o_if_id_valid  out  1  IF/ID holds a real instruction
o_pc  out  NB_BITS  current PC
o_state  out  2  FSM state (IDLE=0, RUN=1, HALTED=2)

Behaviour:
Reset (i_rst=0, asynchronous):
- PC=PC_RST, state=IDLE, o_if_id_pc=0, o_if_id_instr=NOP (0), o_if_id_valid=0.
- Memory contents are not reset.

Instruction memory:
- Combinational read at word index PC[ADDR_W+1:2], so higher PC bits wrap modulo IMEM_DEPTH.
- Synchronous write on i_mem_we; a written word is visible to the fetch in the following cycle.
- Writes are accepted in every state.

FSM:
- IDLE:
  - PC held; IF/ID loads NOP with valid=0 on every edge.
  - i_start -> RUN (first fetch at PC_RST in the next cycle).
- RUN: normal fetch.
  - If the fetched word equals HALT (all ones) and no redirect or flush is active in that cycle:
    - PC does not advance;
    - IF/ID loads the HALT word with valid=1;
    - state -> HALTED.
- HALTED:
  - PC frozen; IF/ID loads NOP with valid=0.
  - i_resume -> RUN with PC <= PC+4.
  - i_start is ignored.

Next PC (RUN only; i_pc_we=1 required, else PC holds and redirects are dropped):
- Priority is i_ctr_jmp > i_ctr_beq > PC+4.
- A redirect or flush in the cycle a HALT word is fetched suppresses the halt: that word is wrong-path.

IF/ID register:
- i_ctr_flush=1 -> NOP, valid=0. This overrides i_if_id_we=0.
- Else if i_if_id_we=1 -> {PC+4, imem[PC], 1}.
- Else hold.

Arithmetic: PC+4 is modulo 2^NB_BITS (wraps at all-ones).

Latency: an instruction fetched at PC appears on the IF/ID outputs one cycle later.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined:
  - adds outputs o_fetch_cnt [31:0] (IF/ID loads with valid=1) and o_bubble_cnt [31:0] (flush loads while in RUN);
  - both cleared by reset and by i_start;
  - both saturate at 0xFFFFFFFF.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg: state encoding (IDLE/RUN/HALTED), NOP and HALT encodings, PC_STEP=4, ADDR_W function.
- Sub-module fetch_imem: single-write-port, combinational-read memory.
- The FSM, PC and IF/ID register stay in fetch_stage_ctrl.

Test Plan:
1. Reset, load imem[0..3]={0x11,0x22,0x33,0xFFFFFFFF}, pulse i_start -> IF/ID sequence (4,0x11),(8,0x22),(12,0x33),(16,HALT,valid=1). Then o_state=HALTED, o_pc=12 frozen, later IF/ID valid=0.
2. In HALTED pulse i_resume with imem[4]=0x55 -> state RUN, next IF/ID = (20,0x55).
3. RUN, i_ctr_jmp=1, i_ctr_beq=1, i_jmp_addr=100, i_brq_addr=40 for one cycle -> o_pc=100 (jump priority). Next cycle beq only -> o_pc=40.
4. i_pc_we=0, i_if_id_we=0 for 3 cycles -> PC and IF/ID hold. i_ctr_flush=1 during the stall -> IF/ID=NOP, valid=0. Release -> fetch resumes at the held PC.
5. HALT word at PC while i_ctr_beq=1 -> no halt, o_pc=i_brq_addr, state stays RUN.
6. Assert i_rst low mid-RUN between clock edges -> outputs reset immediately, state=IDLE, PC=PC_RST. With FETCH_PERF_CNT_EN, both counters read 0.
